muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that sits directly downstream of the register file read ports.
- Takes the rs/rt operands read by the register file and computes MULT/MULTU/DIV/DIVU into private HI/LO registers over a fixed 34-cycle sequence.
- Asserts busy so the control unit stalls the PC while an operation runs.
- HI/LO feed back to the register file write-data mux (MFHI/MFLO) and are written directly by MTHI/MTLO.

Parameters:
WIDTH, 32, operand, HI and LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
clr  input  1  reset, asynchronous, active-low; clears all state
start  input  1  launch an operation; sampled only while busy=0
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
i_A  input  WIDTH  rs operand (multiplicand / dividend)
i_B  input  WIDTH  rt operand (multiplier / divisor)
s_mthi  input  1  write i_A into HI
s_mtlo  input  1  write i_A into LO
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when HI/LO receive a new result
o_hi  output  WIDTH  HI register
o_lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset clr is asynchronous, active-low. While clr=0: state=IDLE, busy=0, done=0, o_hi=0, o_lo=0, counter=0, working registers=0.
- Reset mid-operation aborts the operation; no partial result is written.
- States:
  - IDLE: busy=0. If start=1 at a clk edge: latch op, |i_A|, |i_B| (signed ops take absolute values), the result signs (quotient sign = sign(A) xor sign(B); remainder and product sign rules below), and counter=0. Next state is RUN.
  - RUN: busy=1. One iteration per edge; counter increments; after WIDTH iterations, next state is FIX.
  - FIX: busy=1. Apply sign correction, write o_hi/o_lo, next state IDLE, done=1 for exactly the following cycle.
- Latency: start sampled at edge k. busy=1 from after edge k until after edge k+WIDTH+1. o_hi/o_lo update at edge k+WIDTH+1. done=1 for one cycle after that edge. busy and done are never both 1.
- Multiply: shift-add on a 2*WIDTH accumulator. Signed product = two's-complement negation of the unsigned product when operand signs differ. HI = upper WIDTH bits, LO = lower WIDTH bits.
- Divide: restoring, one quotient bit per iteration. LO = quotient, HI = remainder. Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero: no trap, same latency. LO = all ones. HI = dividend (original i_A, not its absolute value).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (natural wrap; no exception).
- start while busy=1 is ignored; the operation in flight is unaffected.
- s_mthi/s_mtlo:
  - Take effect at the clk edge only in IDLE when start=0.
  - Both high at once writes i_A to both HI and LO.
  - Ignored while busy=1.
  - If start=1 in the same IDLE cycle, start wins and the MT write is dropped.
- op and operand inputs are don't-care except at the start edge; the internal copies are stable for the whole operation.
- o_hi/o_lo hold their previous values throughout RUN/FIX until the FIX edge.

Test Plan:
- Reset: clr=0 mid-RUN after a MULTU start → busy=0, done=0, o_hi=o_lo=0 immediately (asynchronously); no done pulse follows.
- MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF → done after edge k+33, o_hi=0xFFFFFFFE, o_lo=0x00000001; busy high for 33 cycles.
- MULT: A=0xFFFFFFFD (-3), B=7 → o_hi=0xFFFFFFFF, o_lo=0xFFFFFFEB (-21).
- DIV: A=-7, B=2 → o_lo=0xFFFFFFFD (-3), o_hi=0xFFFFFFFF (-1). DIVU: A=100, B=7 → o_lo=14, o_hi=2.
- Boundary divides:
  - DIV 0x80000000/0xFFFFFFFF → o_lo=0x80000000, o_hi=0.
  - DIVU 5/0 → o_lo=0xFFFFFFFF, o_hi=5.
- Control interactions:
  - start pulsed again and s_mthi pulsed mid-RUN → both ignored; result matches the first operation.
  - In IDLE, s_mtlo with i_A=0x12345678 → o_lo=0x12345678 next cycle, o_hi unchanged.
  - start together with s_mthi in IDLE → only the operation result appears.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, followed by a sign-fix cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             s_mthi,
    input  logic             s_mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q;
    logic                 is_div_q, neg_lo_q, neg_hi_q, div_zero_q, done_q;
    logic [WIDTH-1:0]     opnd_q, hi_q, lo_q;
    logic [2*WIDTH-1:0]   work_q;

    logic                 sign_a, sign_b, last;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem, fix_hi, fix_lo;

    assign sign_a = op[0] & i_A[WIDTH-1];
    assign sign_b = op[0] & i_B[WIDTH-1];
    assign abs_a  = sign_a ? -i_A : i_A;
    assign abs_b  = sign_b ? -i_B : i_B;
    assign last   = (cnt_q == CntW'(WIDTH - 1));

    // Multiply: work = {partial sum, remaining multiplier bits}; divide: work = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     work_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        prod = neg_lo_q ? -work_q : work_q;
        quo  = work_q[WIDTH-1:0];
        rem  = work_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            fix_lo = div_zero_q ? '1 : (neg_lo_q ? -quo : quo);
            fix_hi = neg_hi_q ? -rem : rem;
        end else begin
            fix_lo = prod[WIDTH-1:0];
            fix_hi = prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = done_q;
        o_hi = hi_q;
        o_lo = lo_q;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
            done_q     <= 1'b0;
            opnd_q     <= '0;
            work_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt_q      <= '0;
                        is_div_q   <= op[1];
                        div_zero_q <= (i_B == '0);
                        opnd_q     <= op[1] ? abs_b : abs_a;
                        work_q     <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        // Zero divisor keeps the quotient unsigned so LO stays all ones.
                        neg_lo_q   <= (sign_a ^ sign_b) & ~(op[1] & (i_B == '0));
                        neg_hi_q   <= op[1] ? sign_a : (sign_a ^ sign_b);
                    end else begin
                        if (s_mthi) hi_q <= i_A;
                        if (s_mtlo) lo_q <= i_A;
                    end
                end
                StRun: begin
                    cnt_q  <= cnt_q + CntW'(1);
                    work_q <= is_div_q ? div_next : mul_next;
                end
                StFix: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized traffic.
module tb_muldiv_unit;

    localparam int unsigned WIDTH = 32;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] i_A = '0;
    logic [31:0] i_B = '0;
    logic        s_mthi = 1'b0;
    logic        s_mtlo = 1'b0;
    logic        busy, done;
    logic [31:0] o_hi, o_lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .op     (op),
        .i_A    (i_A),
        .i_B    (i_B),
        .s_mthi (s_mthi),
        .s_mtlo (s_mtlo),
        .busy   (busy),
        .done   (done),
        .o_hi   (o_hi),
        .o_lo   (o_lo)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] f_op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        logic [63:0]     p, q, r;
        case (f_op)
            2'd0: p = ua * ub;
            2'd1: p = sa * sb;
            default: begin
                if (b == 32'd0) begin
                    q = '1;
                    r = {32'd0, a};
                end else if (f_op == 2'd2) begin
                    q = ua / ub;
                    r = ua % ub;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
                p = {r[31:0], q[31:0]};
            end
        endcase
        return p;
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] p_res = '0;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    p_res  <= ref_result(op, i_A, i_B);
                    m_busy <= 1'b1;
                    m_cnt  <= WIDTH + 1;
                end else begin
                    if (s_mthi) m_hi <= i_A;
                    if (s_mtlo) m_lo <= i_A;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    m_hi   <= p_res[63:32];
                    m_lo   <= p_res[31:0];
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_busy", 32'(busy), 32'(m_busy));
        check("model_done", 32'(done), 32'(m_done));
        check("model_hi", o_hi, m_hi);
        check("model_lo", o_lo, m_lo);
        check("busy_done_excl", 32'(busy & done), 32'd0);
    end

    task automatic run_op(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit with_mt,
                          output logic [31:0] hi, output logic [31:0] lo, output int nbusy);
        bit seen_done = 1'b0;
        @(negedge clk); #1;
        start = 1'b1; op = f_op; i_A = a; i_B = b; s_mthi = with_mt;
        @(negedge clk); #1;
        start = 1'b0; s_mthi = 1'b0;
        op = 2'($urandom); i_A = $urandom; i_B = $urandom;
        nbusy = busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (disturb && i == 5) begin
                start = 1'b1; s_mthi = 1'b1; op = 2'($urandom); i_A = $urandom;
            end else begin
                start = 1'b0; s_mthi = 1'b0;
            end
        end
        start = 1'b0; s_mthi = 1'b0;
        check("done_timeout", 32'(seen_done), 32'd1);
        hi = o_hi;
        lo = o_lo;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hi, lo;
        int          nb;
        bit          saw_done;

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", o_hi, 32'd0);
        check("rst_lo", o_lo, 32'd0);
        clr = 1'b1;

        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, hi, lo, nb);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        check("multu_busy_cycles", 32'(nb), 32'd33);

        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, hi, lo, nb);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, hi, lo, nb);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);

        run_op(2'd2, 32'd100, 32'd7, 1'b0, 1'b0, hi, lo, nb);
        check("divu_hi", hi, 32'd2);
        check("divu_lo", lo, 32'd14);

        @(negedge clk); #1;
        s_mtlo = 1'b1; i_A = 32'h1234_5678;
        @(negedge clk); #1;
        s_mtlo = 1'b0;
        check("mtlo_lo", o_lo, 32'h1234_5678);
        check("mtlo_hi_kept", o_hi, 32'd2);

        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, hi, lo, nb);
        check("div_ovf_hi", hi, 32'd0);
        check("div_ovf_lo", lo, 32'h8000_0000);

        run_op(2'd2, 32'd5, 32'd0, 1'b0, 1'b0, hi, lo, nb);
        check("divu_zero_hi", hi, 32'd5);
        check("divu_zero_lo", lo, 32'hFFFF_FFFF);
        check("divu_zero_cycles", 32'(nb), 32'd33);

        run_op(2'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0, hi, lo, nb);
        check("div_zero_neg_hi", hi, 32'hFFFF_FFF0);
        check("div_zero_neg_lo", lo, 32'hFFFF_FFFF);

        run_op(2'd2, 32'd100, 32'd7, 1'b1, 1'b0, hi, lo, nb);
        check("disturb_hi", hi, 32'd2);
        check("disturb_lo", lo, 32'd14);

        run_op(2'd0, 32'd6, 32'd7, 1'b0, 1'b1, hi, lo, nb);
        check("start_mthi_hi", hi, 32'd0);
        check("start_mthi_lo", lo, 32'd42);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk); #1;
        s_mthi = 1'b1; i_A = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        s_mthi = 1'b0; start = 1'b1; op = 2'd0; i_A = '1; i_B = '1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_hi", o_hi, 32'd0);
        check("arst_lo", o_lo, 32'd0);
        @(negedge clk); #1;
        clr = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("arst_no_done", 32'(saw_done), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            start  = ($urandom % 4) == 0;
            op     = 2'($urandom);
            i_A    = pick();
            i_B    = pick();
            s_mthi = ($urandom % 8) == 0;
            s_mtlo = ($urandom % 8) == 0;
            if (c == 1500) clr = 1'b0;
            if (c == 1502) clr = 1'b1;
        end
        @(negedge clk); #1;
        start = 1'b0; s_mthi = 1'b0; s_mtlo = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
